// File: rtl/sd_cmd_responder.sv
// sd_cmd_responder: card-side SD CMD line endpoint.
// Receives 48-bit command tokens and checks their CRC7. For good tokens it
// publishes the index and argument, and it can return an R1-format response
// after NCR cycles.
module sd_cmd_responder #(
  parameter int unsigned NCR = 2
) (
  input  logic        clk_SD,
  input  logic        reset_host,
  input  logic        CMD_PIN_IN,
  output logic        CMD_PIN_OUT,
  output logic        io_enable_cmd,
  output logic [5:0]  cmd_index_out,
  output logic [31:0] cmd_argument_out,
  output logic        cmd_received,
  output logic        cmd_crc_error,
  input  logic        respond_en,
  input  logic [31:0] response_status,
  output logic        busy
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RX,
    S_CHECK,
    S_WAIT,
    S_TX
  } state_t;

  state_t      state_q, state_d;
  logic [5:0]  bit_cnt_q, bit_cnt_d;
  logic [6:0]  ncr_cnt_q, ncr_cnt_d;
  logic [6:0]  crc_q, crc_d;
  logic [47:0] rx_q, rx_d;
  logic [39:0] tx_q, tx_d;
  logic [5:0]  idx_q, idx_d;
  logic [31:0] arg_q, arg_d;
  logic        rcv_q, rcv_d;
  logic        err_q, err_d;
  logic        out_q, out_d;
  logic        oe_q, oe_d;

  // One serial CRC7 step for G(x) = x^7 + x^3 + 1.
  function automatic logic [6:0] crc7_step(input logic [6:0] crc, input logic b);
    logic fb;
    fb = b ^ crc[6];
    return {crc[5:3], crc[2] ^ fb, crc[1:0], fb};
  endfunction

  // Next-state and next-output logic for the receive/respond sequence.
  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    ncr_cnt_d = ncr_cnt_q;
    crc_d     = crc_q;
    rx_d      = rx_q;
    tx_d      = tx_q;
    idx_d     = idx_q;
    arg_d     = arg_q;
    rcv_d     = 1'b0;
    err_d     = 1'b0;
    out_d     = out_q;
    oe_d      = oe_q;
    case (state_q)
      S_IDLE: begin
        out_d = 1'b1;
        oe_d  = 1'b0;
        if (!CMD_PIN_IN) begin
          // The start bit is 0, so the shift register and the CRC both
          // start out cleared.
          state_d   = S_RX;
          bit_cnt_d = 6'd1;
          crc_d     = '0;
          rx_d      = '0;
        end
      end
      S_RX: begin
        rx_d      = {rx_q[46:0], CMD_PIN_IN};
        bit_cnt_d = bit_cnt_q + 6'd1;
        if (bit_cnt_q < 6'd40) crc_d = crc7_step(crc_q, CMD_PIN_IN);
        if (bit_cnt_q == 6'd1 && !CMD_PIN_IN) state_d = S_IDLE;
        else if (bit_cnt_q == 6'd47)          state_d = S_CHECK;
      end
      S_CHECK: begin
        state_d = S_IDLE;
        if (rx_q[47:46] == 2'b01 && rx_q[0] && rx_q[7:1] == crc_q) begin
          idx_d = rx_q[45:40];
          arg_d = rx_q[39:8];
          rcv_d = 1'b1;
          if (respond_en) begin
            state_d   = S_WAIT;
            ncr_cnt_d = 7'd1;
          end
        end else begin
          err_d = 1'b1;
        end
      end
      S_WAIT: begin
        if (ncr_cnt_q == 7'(NCR - 1)) begin
          // The start bit goes out on this edge. tx_q holds the remaining
          // header/status bits, with a pad bit at the bottom.
          state_d   = S_TX;
          out_d     = 1'b0;
          oe_d      = 1'b1;
          tx_d      = {1'b0, idx_q, response_status, 1'b0};
          crc_d     = '0;
          bit_cnt_d = 6'd1;
        end else begin
          ncr_cnt_d = ncr_cnt_q + 7'd1;
        end
      end
      S_TX: begin
        bit_cnt_d = bit_cnt_q + 6'd1;
        if (bit_cnt_q < 6'd40) begin
          out_d = tx_q[39];
          tx_d  = {tx_q[38:0], 1'b0};
          crc_d = crc7_step(crc_q, tx_q[39]);
        end else if (bit_cnt_q < 6'd47) begin
          out_d = crc_q[6];
          crc_d = {crc_q[5:0], 1'b0};
        end else if (bit_cnt_q == 6'd47) begin
          out_d = 1'b1;
        end else begin
          out_d   = 1'b1;
          oe_d    = 1'b0;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and registered outputs; reset releases the line at once.
  always_ff @(posedge clk_SD) begin
    if (reset_host) begin
      state_q   <= S_IDLE;
      bit_cnt_q <= '0;
      ncr_cnt_q <= '0;
      crc_q     <= '0;
      rx_q      <= '0;
      tx_q      <= '0;
      idx_q     <= '0;
      arg_q     <= '0;
      rcv_q     <= 1'b0;
      err_q     <= 1'b0;
      out_q     <= 1'b1;
      oe_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      ncr_cnt_q <= ncr_cnt_d;
      crc_q     <= crc_d;
      rx_q      <= rx_d;
      tx_q      <= tx_d;
      idx_q     <= idx_d;
      arg_q     <= arg_d;
      rcv_q     <= rcv_d;
      err_q     <= err_d;
      out_q     <= out_d;
      oe_q      <= oe_d;
    end
  end

  assign CMD_PIN_OUT      = out_q;
  assign io_enable_cmd    = oe_q;
  assign cmd_index_out    = idx_q;
  assign cmd_argument_out = arg_q;
  assign cmd_received     = rcv_q;
  assign cmd_crc_error    = err_q;
  assign busy             = (state_q != S_IDLE);

endmodule

// File: tb/tb_sd_cmd_responder.sv
// Testbench for sd_cmd_responder. The driver pushes the expected events into
// a scoreboard queue, and the monitor pops them and compares at each negedge.
module tb_sd_cmd_responder;

  localparam int unsigned NCR_TB = 2;
  localparam int K_GOOD = 0;
  localparam int K_BAD  = 1;
  localparam int K_RESP = 2;

  logic        clk_SD = 1'b0;
  logic        reset_host = 1'b1;
  logic        CMD_PIN_IN = 1'b1;
  logic        respond_en = 1'b0;
  logic [31:0] response_status = '0;
  logic        CMD_PIN_OUT, io_enable_cmd, cmd_received, cmd_crc_error, busy;
  logic [5:0]  cmd_index_out;
  logic [31:0] cmd_argument_out;

  sd_cmd_responder #(.NCR(NCR_TB)) dut (
    .clk_SD           (clk_SD),
    .reset_host       (reset_host),
    .CMD_PIN_IN       (CMD_PIN_IN),
    .CMD_PIN_OUT      (CMD_PIN_OUT),
    .io_enable_cmd    (io_enable_cmd),
    .cmd_index_out    (cmd_index_out),
    .cmd_argument_out (cmd_argument_out),
    .cmd_received     (cmd_received),
    .cmd_crc_error    (cmd_crc_error),
    .respond_en       (respond_en),
    .response_status  (response_status),
    .busy             (busy)
  );

  always #5 clk_SD = ~clk_SD;

  int unsigned cyc = 0;
  always @(posedge clk_SD) cyc <= cyc + 1;

  typedef struct {
    int          kind;
    int unsigned at;
    logic [5:0]  idx;
    logic [31:0] arg;
    logic [47:0] data;
    int unsigned len;
  } exp_t;

  exp_t        q[$];
  int          tests = 0;
  int          fails = 0;
  logic [5:0]  m_idx = '0;
  logic [31:0] m_arg = '0;
  bit          mon_en = 1'b0;

  // CRC7 as the remainder of polynomial long division by x^7+x^3+1.
  function automatic logic [6:0] crc7_div(input logic [39:0] m);
    logic [46:0] r;
    r = {m, 7'b0};
    for (int i = 46; i >= 7; i--)
      if (r[i]) r = r ^ (47'h89 << (i - 7));
    return r[6:0];
  endfunction

  function automatic logic [47:0] mk_cmd(input logic [5:0] idx, input logic [31:0] arg);
    return {2'b01, idx, arg, crc7_div({2'b01, idx, arg}), 1'b1};
  endfunction

  function automatic logic [47:0] mk_resp(input logic [5:0] idx, input logic [31:0] st);
    return {2'b00, idx, st, crc7_div({2'b00, idx, st}), 1'b1};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic pop_expect(input int kind, output exp_t e, output bit ok);
    if (q.size() == 0) begin
      tests++;
      fails++;
      $display("FAIL unexpected_event: got kind %0d, expected none (cycle %0d)", kind, cyc);
      ok = 1'b0;
    end else begin
      e  = q.pop_front();
      ok = 1'b1;
      check("event_kind", kind, e.kind);
    end
  endtask

  // Monitor: compares DUT events against the scoreboard.
  logic [47:0] rbits = '0;
  int unsigned rcnt = 0;
  int unsigned rstart = 0;
  always @(negedge clk_SD) begin
    exp_t e;
    bit   ok;
    if (mon_en) begin
      if (cmd_received) begin
        pop_expect(K_GOOD, e, ok);
        if (ok) begin
          check("rx_cycle", cyc, e.at);
          check("rx_index", cmd_index_out, e.idx);
          check("rx_arg", cmd_argument_out, e.arg);
        end
      end
      if (cmd_crc_error) begin
        pop_expect(K_BAD, e, ok);
        if (ok) begin
          check("err_cycle", cyc, e.at);
          check("err_index_kept", cmd_index_out, e.idx);
          check("err_arg_kept", cmd_argument_out, e.arg);
        end
      end
      if (io_enable_cmd) begin
        if (rcnt == 0) rstart = cyc;
        rbits = {rbits[46:0], CMD_PIN_OUT};
        rcnt++;
      end else begin
        check("line_idle_high", CMD_PIN_OUT, 1);
        if (rcnt != 0) begin
          pop_expect(K_RESP, e, ok);
          if (ok) begin
            check("resp_start", rstart, e.at);
            check("resp_len", rcnt, e.len);
            check("resp_bits", rbits, e.data >> (48 - e.len));
          end
          rbits = '0;
          rcnt  = 0;
        end
      end
    end
  end

  // Drive one token, starting #1 after an edge. A nonzero rst_bit asserts
  // reset on the edge that would emit that response bit.
  task automatic send(input logic [47:0] tok, input logic resp,
                      input logic [31:0] st, input int unsigned rst_bit);
    int unsigned t0;
    exp_t        e;
    logic        good;
    t0   = cyc + 1;
    good = tok[46] && tok[0] && (tok[7:1] == crc7_div(tok[47:8]));
    if (tok[46]) begin
      if (good) begin
        e.kind = K_GOOD; e.at = t0 + 48; e.idx = tok[45:40]; e.arg = tok[39:8];
        e.data = '0; e.len = 0;
        q.push_back(e);
        m_idx = tok[45:40];
        m_arg = tok[39:8];
        if (resp) begin
          e.kind = K_RESP; e.at = t0 + 47 + NCR_TB; e.idx = '0; e.arg = '0;
          e.data = mk_resp(tok[45:40], st);
          e.len  = (rst_bit != 0) ? rst_bit : 48;
          q.push_back(e);
        end
      end else begin
        e.kind = K_BAD; e.at = t0 + 48; e.idx = m_idx; e.arg = m_arg;
        e.data = '0; e.len = 0;
        q.push_back(e);
      end
    end
    for (int i = 0; i < 48; i++) begin
      CMD_PIN_IN      = tok[47 - i];
      respond_en      = 1'($urandom);
      response_status = $urandom;
      @(posedge clk_SD); #1;
      if (i == 0) check("busy_in_rx", busy, 1);
    end
    CMD_PIN_IN      = 1'b1;
    respond_en      = resp;
    response_status = st;
    @(posedge clk_SD); #1;
    respond_en = 1'($urandom);
    if (good && resp) begin
      repeat (NCR_TB - 1) begin @(posedge clk_SD); #1; end
      response_status = $urandom;
      for (int k = 1; k <= 48; k++) begin
        if (k == rst_bit) begin
          reset_host = 1'b1;
          @(posedge clk_SD); #1;
          check("rst_oe", io_enable_cmd, 0);
          check("rst_line", CMD_PIN_OUT, 1);
          check("rst_busy", busy, 0);
          check("rst_index", cmd_index_out, 0);
          reset_host = 1'b0;
          m_idx = '0;
          m_arg = '0;
          break;
        end
        @(posedge clk_SD); #1;
      end
    end
    repeat ($urandom_range(0, 2)) begin @(posedge clk_SD); #1; end
  endtask

  initial begin
    logic [47:0] tok;
    int unsigned r;
    reset_host = 1'b1;
    repeat (3) @(posedge clk_SD);
    #1;
    check("reset_line", CMD_PIN_OUT, 1);
    check("reset_oe", io_enable_cmd, 0);
    check("reset_index", cmd_index_out, 0);
    check("reset_arg", cmd_argument_out, 0);
    check("reset_rcv", cmd_received, 0);
    check("reset_err", cmd_crc_error, 0);
    check("reset_busy", busy, 0);
    reset_host = 1'b0;
    mon_en     = 1'b1;
    @(posedge clk_SD); #1;

    send(48'h400000000095, 1'b0, 32'h0, 0);           // CMD0
    send(48'h48000001AA87, 1'b0, 32'h0, 0);           // CMD8
    send(mk_cmd(6'd55, 32'h0), 1'b1, 32'h120, 0);     // CMD55 with R1
    send(48'h510000000057, 1'b1, 32'h0, 0);           // CMD17 with a bad CRC
    send({2'b00, 46'h3FFF_FFFF_FFFF}, 1'b1, 32'h0, 0); // foreign response token
    send(48'h400000000095, 1'b0, 32'h0, 0);           // CMD0 again

    for (int n = 0; n < 40; n++) begin
      tok = mk_cmd(6'($urandom), $urandom);
      r   = $urandom_range(0, 4);
      if (r == 0) tok[$urandom_range(1, 7)] = ~tok[$urandom_range(1, 7)];
      if (r == 1) tok[0] = 1'b0;
      send(tok, 1'($urandom), $urandom, 0);
    end

    send(mk_cmd(6'd55, 32'h0), 1'b1, 32'h0000_0120, 20);
    send(48'h48000001AA87, 1'b1, 32'h0000_0900, 0);

    repeat (5) begin @(posedge clk_SD); #1; end
    check("queue_drained", q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2_000_000;
    tests++;
    fails++;
    $display("FAIL timeout: got cycle %0d, expected end of run", cyc);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
